// File: rtl/mem_read_responder.sv
// Memory responder: fixed-latency pipelined reads, acknowledged writes, side-band preload.
// Defining MEM_ADDR_CHECK_EN adds the addr_err pulse output for out-of-range accesses.
module mem_read_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] adr_val,
    output logic [DATA_W-1:0] r_value,
    output logic              r_valid,
    input  logic              w_valid,
    input  logic [ADDR_W-1:0] w_adr,
    input  logic [DATA_W-1:0] w_value,
    output logic              w_ack,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_adr,
    input  logic [DATA_W-1:0] ld_data,
`ifdef MEM_ADDR_CHECK_EN
    output logic              addr_err,
`endif
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, ACK} wstate_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic                           rd_ok, wr_ok, ld_ok;
    logic [DATA_W-1:0]              rd_word;
    logic [RD_LAT-1:0]              vld_q, vld_d;
    logic [RD_LAT-1:0][DATA_W-1:0]  dat_q, dat_d;
    wstate_t                        state_q, state_d;
    logic [15:0]                    rd_cnt_q, rd_cnt_d;
    logic [15:0]                    wr_cnt_q, wr_cnt_d;

    assign rd_ok = in_range(adr_val);
    assign wr_ok = in_range(w_adr);
    assign ld_ok = in_range(ld_adr);

    // Out-of-range reads return zero rather than an aliased word.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[adr_val[IDX_W-1:0]];
        end
    end

    // Writes are gated by reset; preload is not.
    always_ff @(posedge clk) begin
        if (rst && w_valid && wr_ok) begin
            mem[w_adr[IDX_W-1:0]] <= w_value;
        end
        if (ld_en && ld_ok) begin
            mem[ld_adr[IDX_W-1:0]] <= ld_data;
        end
    end

    // Each stage reloads data only when a valid word arrives, so the last stage holds.
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = r_req;
        if (r_req) begin
            dat_d[0] = rd_word;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_comb begin
        state_d  = w_valid ? ACK : IDLE;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (vld_d[RD_LAT-1] && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (w_valid && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q    <= '0;
            dat_q    <= '0;
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            vld_q    <= vld_d;
            dat_q    <= dat_d;
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign r_valid = vld_q[RD_LAT-1];
    assign r_value = dat_q[RD_LAT-1];
    assign w_ack   = (state_q == ACK);
    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;

`ifdef MEM_ADDR_CHECK_EN
    logic [RD_LAT-1:0] oor_q, oor_d;
    logic              addr_err_q, addr_err_d;
    logic              err_sticky_q, err_sticky_d;

    always_comb begin
        oor_d    = '0;
        oor_d[0] = r_req && !rd_ok;
        for (int i = 1; i < RD_LAT; i++) begin
            oor_d[i] = oor_q[i-1];
        end
        addr_err_d   = (vld_d[RD_LAT-1] && oor_d[RD_LAT-1]) || (w_valid && !wr_ok);
        err_sticky_d = err_sticky_q || addr_err_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            oor_q        <= '0;
            addr_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            oor_q        <= oor_d;
            addr_err_q   <= addr_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: two instances (RD_LAT=1 and RD_LAT=3) share one stimulus
// stream and are checked every cycle against an edge-indexed request/response model.
module tb_mem_read_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, r_req, w_valid, ld_en;
    logic [3:0]  adr_val, w_adr, ld_adr;
    logic [15:0] w_value, ld_data;

    logic [15:0] r_value1, r_value3, rd_cnt1, rd_cnt3, wr_cnt1, wr_cnt3;
    logic        r_valid1, r_valid3, w_ack1, w_ack3;
`ifdef MEM_ADDR_CHECK_EN
    logic        addr_err1, addr_err3;
`endif

    mem_read_responder #(.DATA_W(16), .ADDR_W(4), .DEPTH(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .r_req(r_req), .adr_val(adr_val),
        .r_value(r_value1), .r_valid(r_valid1),
        .w_valid(w_valid), .w_adr(w_adr), .w_value(w_value), .w_ack(w_ack1),
        .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err(addr_err1),
`endif
        .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
    );

    mem_read_responder #(.DATA_W(16), .ADDR_W(4), .DEPTH(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .r_req(r_req), .adr_val(adr_val),
        .r_value(r_value3), .r_valid(r_valid3),
        .w_valid(w_valid), .w_adr(w_adr), .w_value(w_value), .w_ack(w_ack3),
        .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err(addr_err3),
`endif
        .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3)
    );

    // Model state: requests are logged by the edge that sampled them.
    logic [15:0] mmem [8];
    bit          req_v   [4096];
    bit          req_oor [4096];
    logic [15:0] req_d   [4096];
    int          edge_n   = 0;
    int          last_rst = -1;
    bit          ev  [2];
    bit          eerr[2];
    logic [15:0] evl [2];
    logic [15:0] erc [2];
    bit          eack;
    bit          w_oor;
    logic [15:0] ewc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        int e;
        int n;
        int lat;
        e = edge_n;
        req_v[e]   = rst && r_req;
        req_oor[e] = (adr_val >= 4'd8);
        req_d[e]   = (adr_val < 4'd8) ? mmem[adr_val[2:0]] : 16'h0000;
        if (!rst) last_rst = e;
        for (int d = 0; d < 2; d++) begin
            lat  = (d == 0) ? 1 : 3;
            n    = e - lat + 1;
            ev[d]   = 1'b0;
            eerr[d] = 1'b0;
            if (!rst) begin
                evl[d] = 16'h0000;
                erc[d] = 16'h0000;
            end else if (n >= 0 && req_v[n] && last_rst < n) begin
                ev[d]   = 1'b1;
                evl[d]  = req_d[n];
                eerr[d] = req_oor[n];
                if (erc[d] != 16'hFFFF) erc[d] = erc[d] + 16'd1;
                $display("rd L%0d edge %0d data %h", lat, e, req_d[n]);
            end
        end
        eack  = 1'b0;
        w_oor = 1'b0;
        if (!rst) begin
            ewc = 16'h0000;
        end else if (w_valid) begin
            eack  = 1'b1;
            w_oor = (w_adr >= 4'd8);
            if (ewc != 16'hFFFF) ewc = ewc + 16'd1;
            if (w_adr < 4'd8) mmem[w_adr[2:0]] = w_value;
        end
        if (ld_en && ld_adr < 4'd8) mmem[ld_adr[2:0]] = ld_data;
        edge_n++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("r_valid_l1", r_valid1, ev[0]);
        chk("r_value_l1", r_value1, evl[0]);
        chk("rd_cnt_l1",  rd_cnt1,  erc[0]);
        chk("r_valid_l3", r_valid3, ev[1]);
        chk("r_value_l3", r_value3, evl[1]);
        chk("rd_cnt_l3",  rd_cnt3,  erc[1]);
        chk("w_ack_l1",   w_ack1,   eack);
        chk("w_ack_l3",   w_ack3,   eack);
        chk("wr_cnt_l1",  wr_cnt1,  ewc);
        chk("wr_cnt_l3",  wr_cnt3,  ewc);
`ifdef MEM_ADDR_CHECK_EN
        chk("addr_err_l1", addr_err1, (ev[0] && eerr[0]) || (eack && w_oor));
        chk("addr_err_l3", addr_err3, (ev[1] && eerr[1]) || (eack && w_oor));
`endif
    endtask

    task automatic idle();
        r_req = 0; w_valid = 0; ld_en = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mmem[i] = 16'h0000;
        evl[0] = 0; evl[1] = 0; erc[0] = 0; erc[1] = 0; ewc = 0;
        rst = 0; idle();
        adr_val = 0; w_adr = 0; w_value = 0; ld_adr = 0; ld_data = 0;

        // Preload under reset.
        for (int i = 0; i < 8; i++) begin
            ld_en = 1; ld_adr = 4'(i); ld_data = 16'(16'h0011 * (i + 1));
            cycle();
        end
        idle();
        cycle(); cycle();
        chk("rst_r_valid", r_valid1, 1'b0);
        chk("rst_rd_cnt",  rd_cnt3,  16'h0000);
        chk("rst_wr_cnt",  wr_cnt1,  16'h0000);
        rst = 1;

        // Back-to-back reads from the first edge with reset released.
        for (int i = 0; i < 8; i++) begin
            r_req = 1; adr_val = 4'(i);
            cycle();
            chk("seq_valid_l1", r_valid1, 1'b1);
            chk("seq_data_l1",  r_value1, 16'(16'h0011 * (i + 1)));
        end
        idle();
        repeat (3) cycle();
        chk("seq_rd_cnt_l1", rd_cnt1, 16'd8);
        chk("seq_rd_cnt_l3", rd_cnt3, 16'd8);
        chk("hold_l3",       r_value3, 16'h0088);

        // Spaced reads on the RD_LAT=3 instance.
        r_req = 1; adr_val = 4'd2; cycle();
        idle(); cycle();
        chk("gap_novalid_l3", r_valid3, 1'b0);
        r_req = 1; adr_val = 4'd5; cycle();
        chk("gap1_valid_l3", r_valid3, 1'b1);
        chk("gap1_data_l3",  r_value3, 16'h0033);
        idle(); cycle();
        chk("gap_novalid2_l3", r_valid3, 1'b0);
        cycle();
        chk("gap2_valid_l3", r_valid3, 1'b1);
        chk("gap2_data_l3",  r_value3, 16'h0066);
        cycle(); cycle();

        // Same-edge read and write: read sees old data.
        ld_en = 1; ld_adr = 4'd4; ld_data = 16'h0055; cycle();
        idle();
        w_valid = 1; w_adr = 4'd4; w_value = 16'hBEEF; r_req = 1; adr_val = 4'd4;
        cycle();
        chk("coll_old_l1", r_value1, 16'h0055);
        chk("coll_ack_l1", w_ack1,   1'b1);
        idle(); r_req = 1; adr_val = 4'd4; cycle();
        chk("coll_new_l1", r_value1, 16'hBEEF);
        idle(); repeat (3) cycle();
        chk("coll_wr_cnt", wr_cnt1,  16'd1);
        chk("coll_new_l3", r_value3, 16'hBEEF);

        // Preload beats a concurrent write to the same word.
        w_valid = 1; w_adr = 4'd3; w_value = 16'hAAAA;
        ld_en = 1; ld_adr = 4'd3; ld_data = 16'hCCCC;
        cycle();
        idle(); r_req = 1; adr_val = 4'd3; cycle();
        chk("ldwin_l1",   r_value1, 16'hCCCC);
        chk("ldwin_wcnt", wr_cnt1,  16'd2);
        idle(); repeat (3) cycle();

        // Reset while a RD_LAT=3 read is in flight; requests during reset are ignored.
        r_req = 1; adr_val = 4'd4; cycle();
        idle(); rst = 0; cycle();
        r_req = 1; adr_val = 4'd1; cycle();
        chk("mid_novalid_l3", r_valid3, 1'b0);
        chk("mid_rd_cnt_l3",  rd_cnt3,  16'h0000);
        chk("mid_wr_cnt_l3",  wr_cnt3,  16'h0000);
        idle(); rst = 1; cycle();
        chk("mid_after_l3", r_valid3, 1'b0);
        cycle(); cycle();
        chk("mid_after2_l3", r_valid3, 1'b0);
        r_req = 1; adr_val = 4'd4; cycle();
        chk("mid_keep_l1", r_value1, 16'hBEEF);
        idle(); repeat (3) cycle();

        // Out-of-range read and write.
        r_req = 1; adr_val = 4'd9; w_valid = 1; w_adr = 4'd12; w_value = 16'h1234;
        cycle();
        chk("oor_valid_l1", r_valid1, 1'b1);
        chk("oor_data_l1",  r_value1, 16'h0000);
        chk("oor_ack_l1",   w_ack1,   1'b1);
        idle();
        for (int i = 0; i < 8; i++) begin
            r_req = 1; adr_val = 4'(i); cycle();
            if (i == 4) chk("oor_noalias_l1", r_value1, 16'hBEEF);
        end
        idle(); repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_read_responder.md
Name: mem_read_responder

Overview:
- Synthesizable external-memory responder. It answers read requests (r_req/adr_val) and write beats (w_valid) issued by inverted_residual_block.
- Returns read data on r_value/r_valid after a fixed, parameterised latency. Accepts writes into an internal word array.
- Replaces the behavioural main-memory model for FPGA/system runs. A side-band load port preloads the feature/weight words.

Parameters:
- DATA_W, 16, word width of r_value, w_value, ld_data.
- ADDR_W, 4, width of all address ports.
- DEPTH, 8, number of stored words (valid addresses 0..DEPTH-1); DEPTH <= 2**ADDR_W.
- RD_LAT, 1, cycles from r_req sampled high to r_valid high; legal range 1..4.

Ports:
- clk, in, 1, single clock, all logic on posedge.
- rst, in, 1, synchronous reset, active-low.
- r_req, in, 1, read request, sampled each posedge.
- adr_val, in, ADDR_W, read address, sampled with r_req.
- r_value, out, DATA_W, read data.
- r_valid, out, 1, r_value valid, one-cycle pulse per request.
- w_valid, in, 1, write beat valid.
- w_adr, in, ADDR_W, write address.
- w_value, in, DATA_W, write data.
- w_ack, out, 1, write committed, pulse one cycle after the accepted beat.
- ld_en, in, 1, preload strobe.
- ld_adr, in, ADDR_W, preload address.
- ld_data, in, DATA_W, preload data.
- rd_cnt, out, 16, completed reads, saturating.
- wr_cnt, out, 16, committed writes, saturating.

Behaviour:
- Reset: rst=0 at a posedge clears all outputs to 0 at that edge: r_valid, r_value, w_ack, rd_cnt, wr_cnt. It also flushes all in-flight read stages and drops any pending w_ack. Memory array is NOT cleared by reset.
- Reset mid-operation: reads in flight never produce r_valid. The first request is accepted on the first posedge with rst=1.
- Read pipeline: no stall. r_req may be high every cycle, giving one response per cycle, in order.
  - Request sampled at edge N produces r_valid=1 and r_value=mem[adr_val] during the cycle after edge N+RD_LAT-1.
  - RD_LAT=1 matches the existing registered-response timing.
- Data is captured from the array at edge N. Later writes do not alter an in-flight response.
- r_value holds its last valid data while r_valid=0; it does not return to 0.
- Write: w_valid=1 at edge N writes mem[w_adr]=w_value at edge N; w_ack=1 for the cycle after edge N. Back-to-back writes are allowed every cycle.
- Read and write to the same address at the same edge: the read returns the OLD data (read-before-write).
- ld_en=1 writes mem[ld_adr]=ld_data. The load port is honoured even while rst=0. It does not count toward wr_cnt and produces no w_ack.
- ld_en and w_valid to the same address at the same edge: ld_data wins, but w_ack and wr_cnt still update for the write.
- Out-of-range address (>= DEPTH): reads return 0, writes are ignored but still acknowledged (base build). See optional feature.
- Counters:
  - rd_cnt increments on each r_valid pulse.
  - wr_cnt increments on each w_ack pulse.
  - Both saturate at 16'hFFFF and do not wrap.
- Internal state: a RD_LAT-deep valid/data shift register plus the array. The only FSM is a two-state write path (IDLE, ACK) per beat, which may re-enter ACK on consecutive cycles.

Optional Feature:
- Macro name: MEM_ADDR_CHECK_EN.
- When defined, the block adds output port addr_err (1 bit, reset 0).
  - addr_err pulses high for one cycle, aligned with r_valid for an out-of-range read, or with w_ack for an out-of-range write.
  - addr_err is sticky-ORed into an internal flag readable as the MSB-side behaviour: the flag only clears on reset. addr_err itself remains a pulse.
- When undefined, the port does not exist. Out-of-range accesses are silently handled as described above.

Test Plan:
- Reset/preload: hold rst=0 and load mem[0..7]=16'h0011..16'h0088 via ld_en; release rst. Expect r_valid=0, rd_cnt=0, wr_cnt=0, and memory retains the loaded values.
- Pipelined reads, RD_LAT=1: r_req high for 8 consecutive cycles with adr_val 0..7. Expect r_valid high for 8 cycles starting one cycle later, r_value 16'h0011..16'h0088 in order, rd_cnt=8.
- RD_LAT=3 gap reads: requests at adr 2 and then adr 5 two cycles apart. Expect r_valid exactly 3 cycles after each request, data 16'h0033 and 16'h0066.
- Write then read, same edge collision: preload mem[4]=16'h0055, then w_valid to adr 4 with 16'hBEEF and r_req adr 4 at the same edge. Expect the read to return 16'h0055 and w_ack the next cycle. A subsequent read returns 16'hBEEF; wr_cnt=1.
- Reset mid-flight: RD_LAT=3, issue reads, and assert rst=0 one cycle later. Expect no r_valid pulse, counters 0, and mem[4] still 16'hBEEF after reset.
- Out-of-range: read adr 9 and write adr 12 (value 16'h1234). Expect r_value=0 with r_valid, w_ack pulse, and no array change. With MEM_ADDR_CHECK_EN, addr_err pulses with each.
